// File: rtl/giraffe_cmd_pkg.sv
// Constants and state encoding shared by the UART command framer and its timer.
package giraffe_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam logic [7:0] CMD_SPI_WR  = 8'h01;
    localparam logic [7:0] CMD_ADC_RST = 8'h02;
    localparam logic [7:0] CMD_START   = 8'h03;

    function automatic int payload_len(input int n_bit);
        return n_bit / 8;
    endfunction

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        PAYLOAD,
        CHK,
        ISSUE,
        WAIT_LO,
        WAIT_HI
    } state_t;

endpackage

// File: rtl/uart_byte_timer.sv
// Inter-byte timeout counter; expire flags the cycle whose closing edge
// brings the count to TIMEOUT_CYC.
module uart_byte_timer #(
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && cnt != CW'(TIMEOUT_CYC)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expire = en && (cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/uart_cmd_framer.sv
// Assembles UART bytes into checksummed command frames and turns them into
// SPI write requests or FSM control pulses.
module uart_cmd_framer #(
    parameter int         SPI_N_BIT     = 96,
    parameter int         UART_NUM_DATA = 8,
    parameter int         TIMEOUT_CYC   = 20000,
    parameter logic [7:0] SYNC_BYTE     = giraffe_cmd_pkg::SYNC_BYTE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [UART_NUM_DATA-1:0] uart_rdata,
    input  logic                     uart_vld,
    input  logic                     spi_csn,
    output logic                     spi_wreq,
    output logic [SPI_N_BIT-1:0]     spi_wdata,
    output logic                     adc_reset_req,
    output logic                     start_req,
    output logic                     busy,
    output logic                     err_chk,
    output logic                     err_cmd,
    output logic                     err_timeout,
    output logic                     err_overrun,
    output logic [7:0]               frame_cnt
);

    import giraffe_cmd_pkg::*;

    localparam int PLEN = payload_len(SPI_N_BIT);
    localparam int PW   = $clog2(PLEN);

    state_t        state;
    logic [7:0]    cmd;
    logic [7:0]    chk_acc;
    logic [PW-1:0] pay_idx;
    logic [5:0]    wait_cnt;
    logic          timed;
    logic          expire;

    assign timed = (state == CMD) || (state == PAYLOAD) || (state == CHK);
    assign busy  = (state != IDLE);

    uart_byte_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (uart_vld || !timed),
        .en    (timed),
        .expire(expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cmd           <= '0;
            chk_acc       <= '0;
            pay_idx       <= '0;
            wait_cnt      <= '0;
            spi_wdata     <= '0;
            frame_cnt     <= '0;
            spi_wreq      <= 1'b0;
            adc_reset_req <= 1'b0;
            start_req     <= 1'b0;
            err_chk       <= 1'b0;
            err_cmd       <= 1'b0;
            err_timeout   <= 1'b0;
            err_overrun   <= 1'b0;
        end else begin
            spi_wreq      <= 1'b0;
            adc_reset_req <= 1'b0;
            start_req     <= 1'b0;
            err_chk       <= 1'b0;
            err_cmd       <= 1'b0;
            err_timeout   <= 1'b0;
            err_overrun   <= 1'b0;
            case (state)
                IDLE: begin
                    if (uart_vld && uart_rdata == SYNC_BYTE) begin
                        chk_acc <= '0;
                        state   <= CMD;
                    end
                end
                CMD: begin
                    if (uart_vld) begin
                        cmd     <= uart_rdata;
                        chk_acc <= chk_acc ^ uart_rdata;
                        pay_idx <= '0;
                        if (uart_rdata == CMD_SPI_WR) begin
                            state <= PAYLOAD;
                        end else if (uart_rdata == CMD_ADC_RST ||
                                     uart_rdata == CMD_START) begin
                            state <= CHK;
                        end else begin
                            err_cmd <= 1'b1;
                            state   <= IDLE;
                        end
                    end else if (expire) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end
                end
                PAYLOAD: begin
                    if (uart_vld) begin
                        spi_wdata <= {spi_wdata[SPI_N_BIT-UART_NUM_DATA-1:0],
                                      uart_rdata};
                        chk_acc   <= chk_acc ^ uart_rdata;
                        pay_idx   <= pay_idx + PW'(1);
                        if (pay_idx == PW'(PLEN - 1)) state <= CHK;
                    end else if (expire) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end
                end
                CHK: begin
                    if (uart_vld) begin
                        if (uart_rdata == chk_acc) begin
                            frame_cnt <= frame_cnt + 8'd1;
                            state     <= ISSUE;
                            if (cmd == CMD_SPI_WR)       spi_wreq      <= 1'b1;
                            else if (cmd == CMD_ADC_RST) adc_reset_req <= 1'b1;
                            else                         start_req     <= 1'b1;
                        end else begin
                            err_chk <= 1'b1;
                            state   <= IDLE;
                        end
                    end else if (expire) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end
                end
                ISSUE: begin
                    wait_cnt    <= '0;
                    err_overrun <= uart_vld;
                    state       <= (cmd == CMD_SPI_WR) ? WAIT_LO : IDLE;
                end
                WAIT_LO: begin
                    // a csn timeout in the same cycle as a stray byte reports the timeout
                    if (!spi_csn) begin
                        state <= WAIT_HI;
                    end else if (wait_cnt == '1) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 6'd1;
                    end
                    err_overrun <= uart_vld && !(spi_csn && wait_cnt == '1);
                end
                WAIT_HI: begin
                    err_overrun <= uart_vld;
                    if (spi_csn) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Bench for uart_cmd_framer: table vectors, timing corner sequences and
// random frame streams checked against a byte-stream reference model.
module tb_uart_cmd_framer;

    localparam int TO = 40;
    localparam int K_NONE = 0, K_SPI = 1, K_ADC = 2, K_START = 3;
    localparam int K_CHK = 4, K_CMD = 5;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        string        name;
        int           n;
        logic [127:0] bytes;
        int           kind;
        logic [95:0]  data;
    } vec_t;

    typedef struct {
        int wreq, adc, start, chk, cmd, to, ovr;
    } cnt_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  uart_rdata;
    logic        uart_vld;
    logic        spi_csn;
    logic        spi_wreq;
    logic [95:0] spi_wdata;
    logic        adc_reset_req;
    logic        start_req;
    logic        busy;
    logic        err_chk;
    logic        err_cmd;
    logic        err_timeout;
    logic        err_overrun;
    logic [7:0]  frame_cnt;

    int n_vec = 0;
    int n_bad = 0;
    logic [7:0] exp_fc = 8'd0;

    int c_wreq = 0, c_adc = 0, c_start = 0, c_chk = 0, c_cmd = 0;
    int c_to = 0, c_ovr = 0, c_excl = 0, c_wide = 0;
    logic [95:0] last_data = '0;
    logic [6:0]  pv;
    logic [6:0]  prev_pv = '0;

    logic auto_csn = 1'b1;
    int   csn_delay = 3;
    int   csn_low_len = 4;

    uart_cmd_framer #(
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .uart_rdata   (uart_rdata),
        .uart_vld     (uart_vld),
        .spi_csn      (spi_csn),
        .spi_wreq     (spi_wreq),
        .spi_wdata    (spi_wdata),
        .adc_reset_req(adc_reset_req),
        .start_req    (start_req),
        .busy         (busy),
        .err_chk      (err_chk),
        .err_cmd      (err_cmd),
        .err_timeout  (err_timeout),
        .err_overrun  (err_overrun),
        .frame_cnt    (frame_cnt)
    );

    initial forever #5 clk = ~clk;

    assign pv = {spi_wreq, adc_reset_req, start_req,
                 err_chk, err_cmd, err_timeout, err_overrun};

    // Pulse monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (spi_wreq) begin
            c_wreq    <= c_wreq + 1;
            last_data <= spi_wdata;
        end
        if (adc_reset_req) c_adc <= c_adc + 1;
        if (start_req) c_start <= c_start + 1;
        if (err_chk) c_chk <= c_chk + 1;
        if (err_cmd) c_cmd <= c_cmd + 1;
        if (err_timeout) c_to <= c_to + 1;
        if (err_overrun) c_ovr <= c_ovr + 1;
        if ($countones(pv[3:0]) > 1) c_excl <= c_excl + 1;
        if (|(pv & prev_pv)) c_wide <= c_wide + 1;
        prev_pv <= pv;
    end

    // SPI master stand-in: csn low then high some time after each request
    initial begin
        spi_csn = 1'b1;
        forever begin
            @(negedge clk);
            if (auto_csn && spi_wreq) begin
                repeat (csn_delay) @(negedge clk);
                spi_csn = 1'b0;
                repeat (csn_low_len) @(negedge clk);
                spi_csn = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic put(input logic [7:0] b);
        uart_rdata = b;
        uart_vld   = 1'b1;
        @(posedge clk);
        #1;
        uart_vld   = 1'b0;
    endtask

    task automatic send(input bq_t q, input int gap_max);
        foreach (q[i]) begin
            put(q[i]);
            if (gap_max > 0 && i != q.size() - 1)
                idle($urandom_range(gap_max, 0));
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 400) begin
            @(posedge clk);
            #1;
            k++;
        end
        idle(2);
        check("idle_wait", 128'(busy), 128'(0));
    endtask

    function automatic cnt_t snap();
        cnt_t s;
        s.wreq = c_wreq; s.adc = c_adc; s.start = c_start;
        s.chk = c_chk; s.cmd = c_cmd; s.to = c_to; s.ovr = c_ovr;
        return s;
    endfunction

    function automatic bq_t to_q(input logic [127:0] v, input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(v[8*(n-1-i) +: 8]);
        return q;
    endfunction

    // Reference: interpret a complete byte stream by the frame rules
    function automatic void ref_model(input bq_t b, output int kind,
                                      output logic [95:0] data);
        int i = 0;
        int plen;
        logic [7:0] x;
        kind = K_NONE;
        data = '0;
        while (i < b.size() && b[i] != 8'hA5) i++;
        if (i + 1 >= b.size()) return;
        x = b[i+1];
        if (x == 8'h00 || x > 8'h03) begin
            kind = K_CMD;
            return;
        end
        plen = (x == 8'h01) ? 12 : 0;
        if (i + 2 + plen >= b.size()) return;
        for (int j = 0; j < plen; j++) begin
            x ^= b[i+2+j];
            data |= 96'(b[i+2+j]) << (8 * (plen - 1 - j));
        end
        if (b[i+2+plen] != x) kind = K_CHK;
        else if (b[i+1] == 8'h01) kind = K_SPI;
        else if (b[i+1] == 8'h02) kind = K_ADC;
        else kind = K_START;
    endfunction

    task automatic expect_frame(input string tag, input cnt_t s0,
                                input int kind, input logic [95:0] data);
        cnt_t s1;
        s1 = snap();
        if (kind >= K_SPI && kind <= K_START) exp_fc = exp_fc + 8'd1;
        check({tag, ".wreq"}, 128'(s1.wreq - s0.wreq), 128'(kind == K_SPI));
        check({tag, ".adc"}, 128'(s1.adc - s0.adc), 128'(kind == K_ADC));
        check({tag, ".start"}, 128'(s1.start - s0.start), 128'(kind == K_START));
        check({tag, ".echk"}, 128'(s1.chk - s0.chk), 128'(kind == K_CHK));
        check({tag, ".ecmd"}, 128'(s1.cmd - s0.cmd), 128'(kind == K_CMD));
        check({tag, ".eto"}, 128'(s1.to - s0.to), 128'(0));
        check({tag, ".eovr"}, 128'(s1.ovr - s0.ovr), 128'(0));
        if (kind == K_SPI) check({tag, ".data"}, 128'(last_data), 128'(data));
        check({tag, ".fc"}, 128'(frame_cnt), 128'(exp_fc));
    endtask

    task automatic run_frame(input string tag, input bq_t q, input int gap,
                             input int kind, input logic [95:0] data);
        cnt_t s0;
        s0 = snap();
        send(q, gap);
        wait_idle();
        expect_frame(tag, s0, kind, data);
    endtask

    vec_t vt[7];

    initial begin
        cnt_t s0, s1;
        bq_t q;
        int k, kind;
        logic saw_lo;
        logic [95:0] d;
        logic [7:0] c, x, p;

        vt[0] = '{"spi_wr", 15, 128'hA501000102030405060708090A0B01,
                  K_SPI, 96'h000102030405060708090A0B};
        vt[1] = '{"adc_rst", 3, 128'hA50202, K_ADC, 96'h0};
        vt[2] = '{"bad_chk", 3, 128'hA50300, K_CHK, 96'h0};
        vt[3] = '{"start", 3, 128'hA50303, K_START, 96'h0};
        vt[4] = '{"lead_junk", 6, 128'h00FF5AA50202, K_ADC, 96'h0};
        vt[5] = '{"bad_cmd", 2, 128'hA507, K_CMD, 96'h0};
        vt[6] = '{"spi_wr2", 15, 128'hA501FFEEDDCCBBAA99887766554401,
                  K_SPI, 96'hFFEEDDCCBBAA998877665544};

        rst = 1'b1;
        uart_vld = 1'b0;
        uart_rdata = 8'h00;
        idle(3);
        check("reset_outs", 128'(pv), 128'(0));
        check("reset_busy", 128'(busy), 128'(0));
        check("reset_fc", 128'(frame_cnt), 128'(0));
        check("reset_wdata", 128'(spi_wdata), 128'(0));
        rst = 1'b0;
        idle(1);

        // SPI write: pulse timing, data, busy across the csn handshake
        csn_delay = 5;
        csn_low_len = 4;
        s0 = snap();
        send(to_q(vt[0].bytes, vt[0].n), 0);
        check("spi.wreq_lat", 128'(spi_wreq), 128'(1));
        check("spi.wdata", 128'(spi_wdata), 128'(vt[0].data));
        check("spi.busy", 128'(busy), 128'(1));
        idle(1);
        check("spi.wreq_1cyc", 128'(spi_wreq), 128'(0));
        saw_lo = 1'b0;
        k = 0;
        while (busy && k < 200) begin
            if (!spi_csn) saw_lo = 1'b1;
            idle(1);
            k++;
        end
        check("spi.csn_seen_lo", 128'(saw_lo), 128'(1));
        check("spi.csn_hi_at_idle", 128'(spi_csn), 128'(1));
        check("spi.wdata_held", 128'(spi_wdata), 128'(vt[0].data));
        idle(2);
        expect_frame("spi_hand", s0, K_SPI, vt[0].data);

        // ADC reset: pulse one cycle after the CHK byte, for one cycle
        s0 = snap();
        send(to_q(vt[1].bytes, vt[1].n), 0);
        check("adc.lat", 128'(adc_reset_req), 128'(1));
        check("adc.no_start", 128'(start_req), 128'(0));
        idle(1);
        check("adc.1cyc", 128'(adc_reset_req), 128'(0));
        wait_idle();
        expect_frame("adc_hand", s0, K_ADC, '0);

        foreach (vt[i])
            run_frame(vt[i].name, to_q(vt[i].bytes, vt[i].n), 0,
                      vt[i].kind, vt[i].data);

        // Inter-byte timeout fires TO edges after the SYNC byte
        s0 = snap();
        put(8'hA5);
        k = 0;
        while (!err_timeout && k < 3 * TO) begin
            idle(1);
            k++;
        end
        check("to.latency", 128'(k), 128'(TO));
        idle(1);
        check("to.1cyc", 128'(err_timeout), 128'(0));
        check("to.idle", 128'(busy), 128'(0));

        // A byte on the expiry edge wins
        s0 = snap();
        put(8'hA5);
        idle(TO - 1);
        put(8'h02);
        put(8'h02);
        check("to_edge.adc", 128'(adc_reset_req), 128'(1));
        wait_idle();
        expect_frame("to_edge", s0, K_ADC, '0);

        // csn never drops: one ISSUE cycle plus 64 WAIT_LO cycles
        auto_csn = 1'b0;
        s0 = snap();
        send(to_q(vt[6].bytes, vt[6].n), 0);
        k = 0;
        while (!err_timeout && k < 200) begin
            idle(1);
            k++;
        end
        check("csn_to.latency", 128'(k), 128'(65));
        wait_idle();
        s1 = snap();
        exp_fc = exp_fc + 8'd1;
        check("csn_to.wreq", 128'(s1.wreq - s0.wreq), 128'(1));
        check("csn_to.count", 128'(s1.to - s0.to), 128'(1));
        check("csn_to.fc", 128'(frame_cnt), 128'(exp_fc));
        auto_csn = 1'b1;

        // Byte during WAIT_HI is an overrun and never starts a frame
        csn_delay = 2;
        csn_low_len = 8;
        s0 = snap();
        send(to_q(vt[0].bytes, vt[0].n), 0);
        k = 0;
        while (spi_csn && k < 100) begin
            idle(1);
            k++;
        end
        put(8'hA5);
        check("ovr.pulse", 128'(err_overrun), 128'(1));
        wait_idle();
        put(8'h02);
        put(8'h02);
        idle(3);
        s1 = snap();
        exp_fc = exp_fc + 8'd1;
        check("ovr.count", 128'(s1.ovr - s0.ovr), 128'(1));
        check("ovr.dropped", 128'(s1.adc - s0.adc), 128'(0));
        check("ovr.no_ecmd", 128'(s1.cmd - s0.cmd), 128'(0));
        check("ovr.fc", 128'(frame_cnt), 128'(exp_fc));

        // Reset after the 5th payload byte
        send(to_q(128'hA5011122334455, 7), 0);
        rst = 1'b1;
        idle(1);
        check("rst_mid.outs", 128'({pv, busy}), 128'(0));
        check("rst_mid.fc", 128'(frame_cnt), 128'(0));
        check("rst_mid.wdata", 128'(spi_wdata), 128'(0));
        rst = 1'b0;
        exp_fc = 8'd0;
        idle(1);
        run_frame("post_rst", to_q(vt[6].bytes, vt[6].n), 1, K_SPI,
                  vt[6].data);

        // Random frame streams
        for (int it = 0; it < 150; it++) begin
            q.delete();
            repeat ($urandom_range(2, 0)) begin
                c = 8'($urandom);
                if (c == 8'hA5) c = 8'h00;
                q.push_back(c);
            end
            q.push_back(8'hA5);
            c = ($urandom_range(9, 0) < 7) ? 8'($urandom_range(3, 1))
                                            : 8'($urandom);
            q.push_back(c);
            if (c inside {[8'h01:8'h03]}) begin
                x = c;
                if (c == 8'h01) begin
                    repeat (12) begin
                        p = 8'($urandom);
                        x ^= p;
                        q.push_back(p);
                    end
                end
                if ($urandom_range(3, 0) == 0) x ^= 8'($urandom_range(255, 1));
                q.push_back(x);
            end
            csn_delay = $urandom_range(20, 1);
            csn_low_len = $urandom_range(6, 1);
            ref_model(q, kind, d);
            run_frame("rand", q, 5, kind, d);
        end

        check("err_exclusive", 128'(c_excl), 128'(0));
        check("pulse_width", 128'(c_wide), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_cmd_framer.md
Name: uart_cmd_framer

Overview:
Command-framing stage directly downstream of uart_rx and upstream of SPI_Controller_Master and Giraffe_FSM. It assembles received UART bytes into checksummed command frames. Valid SPI-write frames become a single-cycle spi_wreq with a 96-bit word; control frames become one-cycle request pulses to the FSM. Framing, timeout and overrun faults are reported as one-cycle error pulses.

Parameters:
SPI_N_BIT, 96, SPI word width; must be a multiple of 8.
UART_NUM_DATA, 8, UART byte width; fixed at 8.
TIMEOUT_CYC, 20000, clk cycles allowed between bytes of a frame (about 10 byte times at 256000 baud and 50 MHz).
SYNC_BYTE, 8'hA5, frame start marker.

Ports:
clk  in  1  system clock (clk_adc domain)
rst  in  1  synchronous reset, active-high
uart_rdata  in  8  received byte
uart_vld  in  1  one-cycle strobe; uart_rdata is valid in that cycle
spi_csn  in  1  SPI chip select from SPI master, used as completion handshake
spi_wreq  out  1  one-cycle SPI write request
spi_wdata  out  SPI_N_BIT  SPI word; held stable from wreq until the SPI transfer completes
adc_reset_req  out  1  one-cycle pulse to FSM
start_req  out  1  one-cycle pulse to FSM
busy  out  1  high in every state except IDLE
err_chk / err_cmd / err_timeout / err_overrun  out  1 each  one-cycle error pulses
frame_cnt  out  8  count of good frames; wraps 255 to 0

Behaviour:
- Frame format: SYNC, CMD, payload, CHK. CHK is the XOR of CMD and all payload bytes.
- CMD 8'h01: SPI write, 12 payload bytes, first byte maps to spi_wdata[95:88].
- CMD 8'h02: ADC reset, 0 payload bytes.
- CMD 8'h03: start, 0 payload bytes.
- Reset (rst=1 at a clock edge): state=IDLE, all outputs 0, frame_cnt=0, spi_wdata=0, partial frame discarded. Reset mid-frame or mid-SPI behaves the same.
- State machine, all transitions taken on uart_vld unless noted:
  - IDLE: SYNC -> CMD. Any other byte is ignored silently.
  - CMD: 01 -> PAYLOAD with byte counter 0. 02 or 03 -> CHK. Any other value -> err_cmd, IDLE.
  - PAYLOAD: shift each byte into spi_wdata. After the 12th byte -> CHK.
  - CHK: byte matches running XOR -> ISSUE. Mismatch -> err_chk, IDLE.
  - ISSUE (one cycle): pulse the output for the command and increment frame_cnt. CMD 01 -> WAIT_LO; 02 or 03 -> IDLE.
  - WAIT_LO: waits for spi_csn=0 -> WAIT_HI. If spi_csn stays high for 64 cycles -> err_timeout, IDLE.
  - WAIT_HI: waits for spi_csn=1 -> IDLE.
- Latency: the request pulse is asserted in the cycle after the cycle in which the CHK byte's uart_vld is sampled (registered output).
- Timeout counter:
  - Runs in CMD, PAYLOAD and CHK; cleared on every uart_vld.
  - When it reaches TIMEOUT_CYC: err_timeout pulse, return to IDLE.
  - If uart_vld arrives in the same cycle the count reaches TIMEOUT_CYC, the byte wins and no timeout fires.
- Overrun: a uart_vld in ISSUE, WAIT_LO or WAIT_HI drops the byte and pulses err_overrun. The byte is not treated as SYNC.
- Running XOR is reset on entry to CMD.
- In PAYLOAD, spi_wdata shifts left by 8 bits with the new byte in the LSBs. It holds its value outside PAYLOAD.
- Error pulses are mutually exclusive per cycle and last exactly one cycle.

Decomposition:
- Package giraffe_cmd_pkg holds:
  - SYNC_BYTE, CMD_SPI_WR, CMD_ADC_RST, CMD_START;
  - payload length (SPI_N_BIT/8);
  - state enum: IDLE, CMD, PAYLOAD, CHK, ISSUE, WAIT_LO, WAIT_HI.
- One sub-module, uart_byte_timer: loadable timeout counter with clear, enable and expire outputs, parameterised by TIMEOUT_CYC. The counter width is $clog2(TIMEOUT_CYC+1).

Test Plan:
- SPI write: bytes A5 01 00 01 02 03 04 05 06 07 08 09 0A 0B 01 -> spi_wreq high exactly 1 cycle with spi_wdata=96'h000102030405060708090A0B, busy high until the modelled csn low-then-high, frame_cnt=1.
- ADC reset: A5 02 02 -> adc_reset_req pulses exactly 1 cycle, one cycle after the CHK vld; start_req stays 0; frame_cnt increments.
- Bad checksum: A5 03 00 -> err_chk pulse, no start_req, frame_cnt unchanged; a following A5 03 03 -> start_req pulse.
- Framing robustness:
  - 00 FF 5A before A5 02 02 -> leading bytes ignored, frame accepted.
  - A5 07 -> err_cmd, state returns to IDLE.
- Timeout:
  - A5 then no byte -> err_timeout exactly TIMEOUT_CYC cycles after the SYNC vld.
  - A byte arriving at exactly TIMEOUT_CYC -> accepted, no error.
  - SPI write with csn held high -> err_timeout after 64 cycles.
- Overrun and reset:
  - Byte during WAIT_HI -> err_overrun pulse, byte dropped.
  - rst asserted after the 5th payload byte -> all outputs 0 next cycle; a new full frame is then accepted normally.
